// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing and sync polarity constants shared by
// the timing generator and the renderer/sprite blocks.
package vga_pkg;

  localparam int VGA_CW       = 10;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  localparam int SYNC_W = 3;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_bits_t;

  function automatic int total_len(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: pixel clock-enable in, sync/de/coordinates/strobes out.
interface vga_timing_if
  import vga_pkg::*;
#(
  parameter int CW = VGA_CW
);
  logic          pix_ce;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  pix_ce,
    output hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    output pix_ce,
    input  hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register with enable and async reset to a supplied idle
// value; DEPTH=0 degenerates to a wire.
module vga_sync_delay #(
  parameter int DEPTH = 0,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clk, rst_n, en, rst_val};
    assign dout        = din;
  end else begin : g_shift
    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    always_comb begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
      if (en) begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= rst_val;
      end else begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator advancing on pix_ce.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CW         = VGA_CW,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit H_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter bit V_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int PIPE_DLY   = 0
) (
  input  logic        clk,
  input  logic        RSTN,
  vga_timing_if.master vif
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL  = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  localparam sync_bits_t SYNC_IDLE = '{hs: ~H_SYNC_POL, vs: ~V_SYNC_POL, de: 1'b0};

  if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_chk_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_chk_dly
    $error("vga_timing_gen: PIPE_DLY must be 0..7");
  end

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  sync_bits_t    sync0_q, sync0_d;
  sync_bits_t    sync_dly;

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    sync0_d       = sync0_q;
    if (vif.pix_ce) begin
      if (x_q == H_LAST) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
      // Decode from the next count so stage 0 lines up with pixel_x/pixel_y.
      sync0_d.de = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
      sync0_d.hs = (int'(x_d) >= HS_START && int'(x_d) < HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
      sync0_d.vs = (int'(y_d) >= VS_START && int'(y_d) < VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync0_q       <= SYNC_IDLE;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      sync0_q       <= sync0_d;
    end
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DLY),
    .W     (SYNC_W)
  ) u_sync_delay (
    .clk     (clk),
    .rst_n   (RSTN),
    .en      (vif.pix_ce),
    .rst_val (SYNC_IDLE),
    .din     (sync0_q),
    .dout    (sync_dly)
  );

  assign vif.hsync       = sync_dly.hs;
  assign vif.vsync       = sync_dly.vs;
  assign vif.de          = sync_dly.de;
  assign vif.pixel_x     = x_q;
  assign vif.pixel_y     = y_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, frame_start_d};
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed/random bench: default 640x480 instance plus a tiny-raster instance
// with PIPE_DLY=2 and active-high syncs, both checked against a tick-count model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic RSTN;
  logic pix_ce;

  always #5 clk = ~clk;

  vga_timing_if #(.CW(10)) vif_a ();
  vga_timing_if #(.CW(5))  vif_b ();

  assign vif_a.pix_ce = pix_ce;
  assign vif_b.pix_ce = pix_ce;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_a, frame_cnt_b;
`endif

  vga_timing_gen dut_a (
    .clk (clk),
    .RSTN(RSTN),
    .vif (vif_a)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frame_cnt_a)
`endif
  );

  vga_timing_gen #(
    .CW(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIPE_DLY(2)
  ) dut_b (
    .clk (clk),
    .RSTN(RSTN),
    .vif (vif_b)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frame_cnt_b)
`endif
  );

  typedef struct {
    int x;
    int y;
    bit hs;
    bit vs;
    bit de;
    bit ls;
    bit fs;
    int fc;
  } exp_t;

  int checks   = 0;
  int failures = 0;
  int n        = 0;   // pixel ticks since reset release
  bit last     = 0;   // previous clk edge carried a tick

  // Raster position (row-major index) reached after k ticks; k=0 is the reset corner.
  function automatic int pos_of(input int k, input int ht, input int vt);
    return (k + ht * vt - 1) % (ht * vt);
  endfunction

  function automatic exp_t model(input int k, input bit tick,
                                 input int ha, input int hf, input int hsn, input int hb,
                                 input int va, input int vf, input int vsn, input int vb,
                                 input bit hpol, input bit vpol, input int d);
    exp_t e;
    int ht, vt, p, m, qx, qy;
    ht   = ha + hf + hsn + hb;
    vt   = va + vf + vsn + vb;
    p    = pos_of(k, ht, vt);
    e.x  = p % ht;
    e.y  = p / ht;
    e.ls = tick && (e.x == 0);
    e.fs = tick && (p == 0);
    e.fc = (k == 0) ? 0 : (((k - 1) / (ht * vt) + 1) % 65536);
    m    = k - d;
    if (m < 1) begin
      e.de = 1'b0;
      e.hs = ~hpol;
      e.vs = ~vpol;
    end else begin
      qx   = pos_of(m, ht, vt) % ht;
      qy   = pos_of(m, ht, vt) / ht;
      e.de = (qx < ha) && (qy < va);
      e.hs = (qx >= ha + hf && qx < ha + hf + hsn) ? hpol : ~hpol;
      e.vs = (qy >= va + vf && qy < va + vf + vsn) ? vpol : ~vpol;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t ea, eb;
    ea = model(n, last, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0);
    eb = model(n, last, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1, 2);
    chk("a_pixel_x",     32'(vif_a.pixel_x),     32'(ea.x));
    chk("a_pixel_y",     32'(vif_a.pixel_y),     32'(ea.y));
    chk("a_hsync",       32'(vif_a.hsync),       32'(ea.hs));
    chk("a_vsync",       32'(vif_a.vsync),       32'(ea.vs));
    chk("a_de",          32'(vif_a.de),          32'(ea.de));
    chk("a_line_start",  32'(vif_a.line_start),  32'(ea.ls));
    chk("a_frame_start", 32'(vif_a.frame_start), 32'(ea.fs));
    chk("b_pixel_x",     32'(vif_b.pixel_x),     32'(eb.x));
    chk("b_pixel_y",     32'(vif_b.pixel_y),     32'(eb.y));
    chk("b_hsync",       32'(vif_b.hsync),       32'(eb.hs));
    chk("b_vsync",       32'(vif_b.vsync),       32'(eb.vs));
    chk("b_de",          32'(vif_b.de),          32'(eb.de));
    chk("b_line_start",  32'(vif_b.line_start),  32'(eb.ls));
    chk("b_frame_start", 32'(vif_b.frame_start), 32'(eb.fs));
`ifdef VGA_FRAME_CNT_EN
    chk("a_frame_cnt",   32'(frame_cnt_a),       32'(ea.fc));
    chk("b_frame_cnt",   32'(frame_cnt_b),       32'(eb.fc));
`endif
  endtask

  // One clk cycle with the given pix_ce, then sample 2 time units after the edge.
  task automatic step(input bit ce);
    pix_ce = ce;
    @(posedge clk);
    if (RSTN) begin
      if (ce) n++;
      last = ce;
    end else begin
      last = 1'b0;
    end
    #2;
    check_all();
  endtask

  initial begin
    RSTN   = 1'b1;
    pix_ce = 1'b0;
    #1 RSTN = 1'b0;

    // Reset state, including pix_ce pulses that must be ignored while in reset.
    step(1'b0);
    step(1'b1);
    step(1'b0);
    RSTN = 1'b1;

    // First tick lands on (0,0) with both strobes and de.
    step(1'b1);

    // Continuous pix_ce: full default line plus many tiny frames.
    for (int i = 0; i < 1000; i++) step(1'b1);

    // One tick in four: counters must freeze and strobes stay 1 clk wide.
    for (int i = 0; i < 1200; i++) step((i % 4) == 3);

    // Random pix_ce.
    for (int i = 0; i < 800; i++) step(1'b1 & 1'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of a line.
    #1;
    RSTN = 1'b0;
    n    = 0;
    last = 1'b0;
    #1;
    check_all();
    step(1'b1);
    step(1'b1);
    RSTN = 1'b1;
    step(1'b1);

    for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)));
    for (int i = 0; i < 400; i++) step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
